// File: rtl/booth_radix4_mul.sv
// booth_radix4_mul -- sequential radix-4 Booth multiplier, signed or unsigned.
//
// Both operands are widened to N+2 bits, so one encoding covers both modes:
// sign-extended for two's complement, zero-extended for unsigned. The multiply
// then takes N/2+1 radix-4 steps. A result is presented with Valid and held
// until Ack. Abort cancels a running operation.
//
// Ports
//   Clk   : clock, rising edge
//   Rst   : synchronous active-high reset, highest priority
//   Ld    : start request (taken in IDLE, or in DONE together with Ack)
//   Sgn   : 1 = two's complement operands, 0 = unsigned (sampled with Ld)
//   M, R  : multiplicand / multiplier, N bits (sampled on acceptance)
//   Abort : cancel in RUN; acts as Ack in DONE; ignored in IDLE
//   Ack   : consumer acknowledge of the presented result
//   Busy  : high whenever the FSM is not IDLE
//   Valid : result present on P
//   P     : low 2N bits of the exact product
module booth_radix4_mul #(
  parameter int N = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Ld,
  input  logic             Sgn,
  input  logic [N-1:0]     M,
  input  logic [N-1:0]     R,
  input  logic             Abort,
  input  logic             Ack,
  output logic             Busy,
  output logic             Valid,
  output logic [2*N-1:0]   P
);

  localparam int XW    = N + 2;          // extended operand width
  localparam int AW    = N + 3;          // accumulator width (holds +/-2M)
  localparam int STEPS = N / 2 + 1;      // radix-4 steps over XW multiplier bits
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] STEPS_C = CW'(STEPS);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  if ((N % 2 != 0) || (N < 4) || (N > 32)) begin : g_bad_width
    $error("booth_radix4_mul: N must be even and within 4..32");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth recode of {R[2i+1], R[2i], R[2i-1]} into {negate, double, single}.
  function automatic logic [2:0] booth_recode(input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: booth_recode = 3'b001;  // +M
      3'b011:         booth_recode = 3'b010;  // +2M
      3'b100:         booth_recode = 3'b110;  // -2M
      3'b101, 3'b110: booth_recode = 3'b101;  // -M
      default:        booth_recode = 3'b000;  // 0 (000, 111)
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [XW-1:0]   m_q, m_d;
  logic [XW-1:0]   r_q, r_d;
  logic            guard_q, guard_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  p_q, p_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic            accept_s;
  logic            last_s;
  logic [2:0]      code_s;
  logic [AW-1:0]   addend_s;
  logic [AW-1:0]   operand_s;
  logic [AW-1:0]   sum_s;
  logic [AW-1:0]   acc_shift_s;
  logic [XW-1:0]   r_shift_s;
  logic [2*N-1:0]  prod_s;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      m_q     <= {XW{1'b0}};
      r_q     <= {XW{1'b0}};
      guard_q <= 1'b0;
      acc_q   <= {AW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      p_q     <= {(2*N){1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      r_q     <= r_d;
      guard_q <= guard_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; Abort outranks completion of the final step.
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    last_s   = (cnt_q == ONE_C);
    case (state_q)
      IDLE: begin
        if (Ld) begin
          state_d  = RUN;
          accept_s = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (Abort) begin
          state_d = IDLE;
        end else if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (Abort) begin
          state_d = IDLE;                 // behaves as Ack, Ld not taken
        end else if (Ack && Ld) begin
          state_d  = RUN;
          accept_s = 1'b1;
        end else if (Ack) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One Booth step: a single adder fed by an operand mux; subtraction is
  // the inverted operand with carry-in 1. The whole {acc, r, guard} word then
  // shifts right arithmetically by two.
  always_comb begin
    code_s = booth_recode({r_q[1:0], guard_q});
    if (code_s[1]) begin
      addend_s = {m_q, 1'b0};
    end else if (code_s[0]) begin
      addend_s = {m_q[XW-1], m_q};
    end else begin
      addend_s = {AW{1'b0}};
    end
    operand_s   = code_s[2] ? ~addend_s : addend_s;
    sum_s       = acc_q + operand_s + {{(AW-1){1'b0}}, code_s[2]};
    acc_shift_s = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
    r_shift_s   = {sum_s[1:0], r_q[XW-1:2]};
    // {acc, r} now holds the full product; keep its low 2N bits.
    prod_s      = {acc_shift_s[N-3:0], r_shift_s};
  end

  // Register next values and outputs.
  always_comb begin
    m_d     = m_q;
    r_d     = r_q;
    guard_d = guard_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    if (accept_s) begin
      m_d     = Sgn ? {{2{M[N-1]}}, M} : {2'b00, M};
      r_d     = Sgn ? {{2{R[N-1]}}, R} : {2'b00, R};
      guard_d = 1'b0;
      acc_d   = {AW{1'b0}};
      cnt_d   = STEPS_C;
    end else if ((state_q == RUN) && !Abort) begin
      acc_d   = acc_shift_s;
      r_d     = r_shift_s;
      guard_d = r_q[1];
      cnt_d   = cnt_q - ONE_C;
      if (last_s) begin
        p_d = prod_s;
      end else begin
        p_d = p_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  assign Busy  = busy_q;
  assign Valid = valid_q;
  assign P     = p_q;

endmodule

// File: doc/booth_radix4_mul.md
BOOTH_RADIX4_MUL -- requirements
Module: booth_radix4_mul

Interface
REQ-001 SHALL have parameter N, default 8: operand width; must be even, range 4..32; elaboration fails otherwise.
REQ-002 SHALL have port Clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port Ld, input, 1: start request; accepted only as defined in REQ-012.
REQ-005 SHALL have port Sgn, input, 1: operand mode, sampled with Ld; 1 = two's complement, 0 = unsigned.
REQ-006 SHALL have port M, input, N: multiplicand, sampled on acceptance.
REQ-007 SHALL have port R, input, N: multiplier, sampled on acceptance.
REQ-008 SHALL have port Abort, input, 1: cancels an operation in progress.
REQ-009 SHALL have port Ack, input, 1: consumer acknowledge of a presented result.
REQ-010 SHALL have port Busy, output, 1: high in any state other than IDLE.
REQ-011 SHALL have ports Valid, output, 1 (result present) and P, output, 2N (product).

Function
REQ-012 SHALL implement FSM IDLE/RUN/DONE; Ld is accepted in IDLE, or in DONE together with Ack; Ld is ignored in RUN.
REQ-013 SHALL, on acceptance, register M and R extended to N+2 bits (sign-extend if Sgn=1, zero-extend if Sgn=0), clear the Booth guard bit, load the step counter with N/2+1, and enter RUN.
REQ-014 SHALL, on each RUN edge, do one radix-4 Booth step on recode triplet {R[2i+1],R[2i],R[2i-1]}, adding 0, +M, +2M, -M or -2M; accumulator width N+3; the partial product shifts right arithmetically by 2.
REQ-015 SHALL form -M and -2M as the inverted operand plus carry-in 1, using one adder preceded by an operand mux.
REQ-016 SHALL, on the edge that completes the last step, load P with the low 2N bits of the exact product, set Valid=1, and enter DONE.
REQ-017 SHALL give latency N/2+1 edges: with acceptance at edge E0, Valid is first high after edge E0+N/2+1.
REQ-018 SHALL hold Valid and P stable in DONE until Ack=1; at that edge Valid clears and the FSM goes to IDLE, or to RUN if Ld=1 (back-to-back start, new operands sampled).
REQ-019 SHALL, on Abort=1 in RUN, return to IDLE at that edge, with Valid staying 0 and P keeping its previous value.
REQ-020 SHALL treat Abort=1 in DONE as Ack, with Ld ignored on that edge; SHALL ignore Abort in IDLE.
REQ-021 SHALL give Abort priority over the completion of the final step when both fall on the same edge: no Valid, P unchanged.
REQ-022 SHALL produce results exact for all inputs, including signed -2^(N-1) x -2^(N-1) = 2^(2N-2) and unsigned (2^N-1)^2.
REQ-023 SHALL keep Sgn, M and R changes outside the acceptance edge from affecting an operation in progress.

Reset
REQ-024 SHALL give Rst priority over all inputs, in every state.
REQ-025 SHALL, on a Rst edge, force FSM=IDLE, Busy=0, Valid=0, P=0, and clear the counter, accumulator, guard bit and operand registers.
REQ-026 SHALL, on Rst mid-RUN or in DONE, discard the operation; a Ld on the first edge after Rst deasserts is accepted normally.

Verification (N=8)
REQ-027 SHALL cover: Sgn=1, M=0x80, R=0x80, Ld -> Valid after 5 edges, P=0x4000; Busy high for those 5 cycles.
REQ-028 SHALL cover: Sgn=0, M=0xFF, R=0xFF -> P=0xFE01; same operands with Sgn=1 -> P=0x0001; Sgn=1, M=0xFF, R=0x01 -> P=0xFFFF.
REQ-029 SHALL cover: result held with Ack=0 for 10 cycles -> P and Valid stable; Ack=1 together with Ld (M=3, R=5) -> next Valid 5 edges later with P=0x000F.
REQ-030 SHALL cover: Abort asserted 2 edges after acceptance -> IDLE next cycle, Valid never rises, P keeps the prior result; Ld during RUN -> ignored.
REQ-031 SHALL cover: Rst asserted mid-RUN -> P=0, Valid=0, Busy=0 after that edge; a following Ld of 7x9 -> P=0x003F.
REQ-032 SHALL cover: a randomized compare of 10k operations, both modes, against a reference product, plus an N=16 build (latency 9).
